// File: rtl/instruction_fetch.sv
// IF stage: fetches instruction words over a req/ack handshake, buffers them in a
// 2-entry prefetch queue and drives the IF/ID register (PC2/IR2/valid2) for decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC2,
  output logic [31:0] IR2,
  output logic        valid2,
  output logic [1:0]  q_count
);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc;
  logic [31:0] discard_addr;
  logic [31:0] q_pc [2];
  logic [31:0] q_ir [2];

  logic accepted, load_en, pop, bypass, enq;

  assign accepted = imem_req && imem_ack;
  assign load_en  = !stall && !redirect_valid;
  assign pop      = load_en && (q_count != 2'd0);
  assign bypass   = load_en && (q_count == 2'd0) && (state == FETCH) && accepted;
  assign enq      = (state == FETCH) && accepted && !redirect_valid && !bypass;

  // A request raised in FETCH is never withdrawn: the queue cannot grow without an ack,
  // so the q_count/stall condition stays true until the handshake completes.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_req = (q_count != 2'd2) || !stall;
        if (redirect_valid && imem_req && !imem_ack)
          state_next = DISCARD;
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = discard_addr;
        if (imem_ack)
          state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      discard_addr <= RESET_PC;
    end else begin
      state <= state_next;
      if (state == FETCH && redirect_valid && imem_req && !imem_ack)
        discard_addr <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= redirect_pc;
      else if (state == FETCH && accepted)
        fetch_pc <= fetch_pc + 32'(PC_STEP);
    end
  end

  // Head lives in entry 0; a simultaneous pop and enqueue shifts entry 1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_count <= 2'd0;
      q_pc[0] <= 32'h0;
      q_pc[1] <= 32'h0;
      q_ir[0] <= 32'h0;
      q_ir[1] <= 32'h0;
    end else if (redirect_valid) begin
      q_count <= 2'd0;
    end else begin
      case ({pop, enq})
        2'b10: begin
          q_pc[0] <= q_pc[1];
          q_ir[0] <= q_ir[1];
          q_count <= q_count - 2'd1;
        end
        2'b01: begin
          q_pc[q_count[0]] <= imem_addr;
          q_ir[q_count[0]] <= imem_rdata;
          q_count          <= q_count + 2'd1;
        end
        2'b11: begin
          if (q_count == 2'd1) begin
            q_pc[0] <= imem_addr;
            q_ir[0] <= imem_rdata;
          end else begin
            q_pc[0] <= q_pc[1];
            q_ir[0] <= q_ir[1];
            q_pc[1] <= imem_addr;
            q_ir[1] <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // IF/ID register: redirect squashes, stall holds, otherwise queue head, bypass, or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC2    <= 32'h0;
      IR2    <= NOP_INSTR;
      valid2 <= 1'b0;
    end else if (redirect_valid) begin
      IR2    <= NOP_INSTR;
      valid2 <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        PC2    <= q_pc[0];
        IR2    <= q_ir[0];
        valid2 <= 1'b1;
      end else if (bypass) begin
        PC2    <= imem_addr;
        IR2    <= imem_rdata;
        valid2 <= 1'b1;
      end else begin
        IR2    <= NOP_INSTR;
        valid2 <= 1'b0;
      end
    end
  end

endmodule
